pwm_duty_ramp_ctrl: RTL and testbench
=====================================

Name: pwm_duty_ramp_ctrl

Overview:
Sequencer that drives the four 8-bit PWM duty-cycle registers (gen0 ch0/ch1, gen1 ch0/ch1) so each ramps from its current value to a commanded target at a programmable rate.
Per-channel fade commands arrive over a valid/ready handshake from the SPI register layer.
A single shared saturating step unit is time-multiplexed across the channels by a round-robin scan.
Outputs feed the PWM peripheral duty-cycle inputs directly.

Parameters:
NUM_CH, 4, number of ramped channels (fixed at 4; channel index is 2 bits)
RESET_DUTY, 8'h00, reset value of every duty output

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick_div  input  8  prescaler terminal count; a ramp tick fires every tick_div+1 clk cycles
cmd_valid  input  1  fade command valid
cmd_ready  output  1  controller can accept a command this cycle
cmd_ch  input  2  channel index (0=gen0ch0, 1=gen0ch1, 2=gen1ch0, 3=gen1ch1)
cmd_target  input  8  target duty value
cmd_step  input  8  per-tick increment magnitude; 0 = jump directly to target
duty_out  output  32  packed duty values; channel n occupies bits [8n+7:8n]
busy  output  4  channel n is still ramping
done  output  4  one-cycle pulse when channel n reaches its target

Behaviour:
- Reset (async, rst_n=0):
  - duty_out = RESET_DUTY per channel; targets = RESET_DUTY; steps = 0.
  - busy = 0, done = 0, prescaler = 0, state = IDLE, pending = 0, cmd_ready = 1.
- Prescaler:
  - 8-bit counter increments every cycle.
  - When counter == tick_div, it returns to 0 and asserts tick for one cycle.
  - tick_div = 0 gives a tick every cycle.
- FSM states: IDLE, SCAN.
  - IDLE: on tick, go to SCAN with idx = 0.
  - SCAN: lasts exactly 4 cycles; idx = 0,1,2,3; channel idx is serviced in the cycle idx is presented.
  - After idx = 3: if pending, clear pending and restart SCAN at idx 0; else go to IDLE.
- Tick during SCAN:
  - Sets the 1-deep pending flag.
  - Further ticks while pending is already set are dropped.
  - Effective minimum tick period is therefore 4 cycles.
- Service of channel c (registered; visible on duty_out the next cycle):
  - duty < target: duty = min(duty + step, target). Computed 9-bit; saturates at target, never wraps past 255.
  - duty > target: duty = max(duty - step, target). Never underflows below 0.
  - step = 0 and duty != target: duty = target.
  - duty == target: no change.
  - If busy[c] and the new duty == target: clear busy[c] and pulse done[c] in the same cycle the new duty appears.
- Command handshake:
  - cmd_ready = 1 only in IDLE.
  - Transfer occurs when cmd_valid & cmd_ready; store target[cmd_ch] and step[cmd_ch].
  - busy[cmd_ch] = (cmd_target != duty[cmd_ch]).
  - A command whose target equals the current duty: busy stays 0, no done pulse.
  - A new command to a busy channel overrides the target and step; the ramp continues from the current duty and no done pulse is issued for the aborted ramp.
- Simultaneous command and tick in IDLE:
  - The command is accepted and the FSM enters SCAN in the same edge.
  - The new target is used when its channel is serviced.
- Only the scan updates duty; commands never write duty directly.

Optional Feature:
PWM_RAMP_IRQ_EN
- Defined:
  - Adds ports irq (output, 1) and irq_clr (input, 1).
  - irq is a sticky flag set by any done pulse; reset value 0.
  - irq_clr = 1 clears it.
  - If a done pulse and irq_clr occur in the same cycle, set wins.
- Not defined:
  - Neither port exists; no other behaviour changes.

Test Plan:
- Reset with duty nonzero in the middle of a ramp -> duty_out = 32'h0, busy = 0, cmd_ready = 1, prescaler restarts at 0.
- tick_div=3; cmd ch0 target=10, step=4 -> duty0 steps 0→4→8→10 on successive scans; done[0] pulses once with duty0 = 10; busy[0] clears in that same cycle.
- Channel 2 at duty 250; cmd ch2 target=255, step=20 -> duty2 = 255 after one service (saturates, no wrap). Then cmd target=3, step=100 -> 155, 55, 3.
- cmd ch1 target=200, step=0 -> duty1 = 200 at the first ch1 service after the command, with a done pulse. Repeating the same command -> busy[1] stays 0, no done pulse.
- tick_div=0 (tick every cycle) -> scans run back-to-back with pending set. Each channel is serviced exactly once per 4 cycles and cmd_ready stays 0 throughout; with tick_div=0 the FSM never returns to IDLE, so the command is never accepted.
- Mid-ramp override: ch3 ramping 0→100 step 10, reaches 40; new command target=20, step=10 -> 30, 20, single done pulse. With PWM_RAMP_IRQ_EN, irq rises with that pulse and clears on irq_clr.

Source files
------------

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Fade-command handshake between the SPI register layer (master) and the
// duty ramp controller (slave).
interface pwm_duty_ramp_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_ch;
    logic [7:0] cmd_target;
    logic [7:0] cmd_step;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_target,
        output cmd_step,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_target,
        input  cmd_step,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// Ramps four PWM duty registers toward commanded targets using one shared step unit
// scanned round-robin. Optional sticky done interrupt: define PWM_RAMP_IRQ_EN.
module pwm_duty_ramp_ctrl #(
    parameter int unsigned NUM_CH     = 4,
    parameter logic [7:0]  RESET_DUTY = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            tick_div,
    pwm_duty_ramp_ctrl_if.slave   cmd,
    output logic [8*NUM_CH-1:0]   duty_out,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     done
`ifdef PWM_RAMP_IRQ_EN
    ,
    input  logic                  irq_clr,
    output logic                  irq
`endif
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        pending_q, pending_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        tick;
    logic        cmd_fire;
    logic        svc_en;

    logic [7:0]        duty_q   [NUM_CH];
    logic [7:0]        duty_d   [NUM_CH];
    logic [7:0]        target_q [NUM_CH];
    logic [7:0]        target_d [NUM_CH];
    logic [7:0]        step_q   [NUM_CH];
    logic [7:0]        step_d   [NUM_CH];
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] done_q, done_d;

    logic [7:0] svc_duty, svc_tgt, svc_step, svc_diff, svc_new;
    logic [8:0] svc_sum;

    assign tick  = (cnt_q == tick_div);
    assign cnt_d = tick ? 8'd0 : cnt_q + 8'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= 2'd0;
            pending_q <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic; a tick landing on the last scan slot counts as pending
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StScan;
                    idx_d   = 2'd0;
                end
            end
            StScan: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    pending_d = 1'b0;
                    if (!(pending_q || tick)) begin
                        state_d = StIdle;
                    end
                end else if (tick) begin
                    pending_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        cmd.cmd_ready = (state_q == StIdle);
        svc_en        = (state_q == StScan);
        cmd_fire      = cmd.cmd_valid && (state_q == StIdle);
    end

    // Shared step unit; both directions clamp at the target so no wrap is possible
    always_comb begin
        svc_duty = duty_q[idx_q];
        svc_tgt  = target_q[idx_q];
        svc_step = step_q[idx_q];
        svc_sum  = {1'b0, svc_duty} + {1'b0, svc_step};
        svc_diff = svc_duty - svc_tgt;
        svc_new  = svc_duty;
        if (svc_step == 8'd0) begin
            svc_new = svc_tgt;
        end else if (svc_duty < svc_tgt) begin
            svc_new = (svc_sum >= {1'b0, svc_tgt}) ? svc_tgt : svc_sum[7:0];
        end else if (svc_duty > svc_tgt) begin
            svc_new = (svc_diff <= svc_step) ? svc_tgt : svc_duty - svc_step;
        end
    end

    // Service and command updates are mutually exclusive (SCAN vs IDLE)
    always_comb begin
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        busy_d   = busy_q;
        done_d   = '0;
        if (svc_en) begin
            duty_d[idx_q] = svc_new;
            if (busy_q[idx_q] && (svc_new == svc_tgt)) begin
                busy_d[idx_q] = 1'b0;
                done_d[idx_q] = 1'b1;
            end
        end
        if (cmd_fire) begin
            target_d[cmd.cmd_ch] = cmd.cmd_target;
            step_d[cmd.cmd_ch]   = cmd.cmd_step;
            busy_d[cmd.cmd_ch]   = (cmd.cmd_target != duty_q[cmd.cmd_ch]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i]   <= RESET_DUTY;
                target_q[i] <= RESET_DUTY;
                step_q[i]   <= 8'd0;
            end
            busy_q <= '0;
            done_q <= '0;
        end else begin
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        duty_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_out[8*i +: 8] = duty_q[i];
        end
        busy = busy_q;
        done = done_q;
    end

`ifdef PWM_RAMP_IRQ_EN
    logic irq_q, irq_d;

    // A done pulse overrides a simultaneous clear
    always_comb begin
        irq_d = (irq_q && !irq_clr) || (|done_q);
        irq   = irq_q || (|done_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed, table-driven bench for pwm_duty_ramp_ctrl; optional irq checks follow
// PWM_RAMP_IRQ_EN.
module tb_pwm_duty_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  tick_div;
    logic [31:0] duty_out;
    logic [3:0]  busy;
    logic [3:0]  done;
`ifdef PWM_RAMP_IRQ_EN
    logic        irq;
    logic        irq_clr;
`endif

    pwm_duty_ramp_ctrl_if bus ();

    pwm_duty_ramp_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_div (tick_div),
        .cmd      (bus),
        .duty_out (duty_out),
        .busy     (busy),
        .done     (done)
`ifdef PWM_RAMP_IRQ_EN
        ,
        .irq_clr  (irq_clr),
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int              ch;
        int              init;
        int              tgt;
        int              stp;
        int              n;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vt [8];
    int   n_vec = 0;
    int   n_bad = 0;
    int   done_cnt [4];
    int   cur [4];

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (done[c] === 1'b1) done_cnt[c]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(int ch, int init, int tgt, int stp, int n,
                                int e0, int e1, int e2, int e3);
        vec_t v;
        v.ch     = ch;
        v.init   = init;
        v.tgt    = tgt;
        v.stp    = stp;
        v.n      = n;
        v.exp[0] = e0[7:0];
        v.exp[1] = e1[7:0];
        v.exp[2] = e2[7:0];
        v.exp[3] = e3[7:0];
        return v;
    endfunction

    function automatic logic [7:0] duty_of(int ch);
        return duty_out[8*ch +: 8];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out, expected event not seen", name);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int ch, input int tgt, input int stp);
        int k;
        bus.cmd_valid  = 1'b1;
        bus.cmd_ch     = ch[1:0];
        bus.cmd_target = tgt[7:0];
        bus.cmd_step   = stp[7:0];
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 100) begin
            cyc();
            k++;
        end
        if (k >= 100) timeout_fail("cmd_accept");
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_change(input int ch, input logic [7:0] prev,
                               output logic [7:0] val, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            cyc();
            if (duty_of(ch) !== prev) begin
                ok = 1'b1;
                break;
            end
        end
        val = duty_of(ch);
        if (!ok) timeout_fail($sformatf("duty%0d_change", ch));
    endtask

    task automatic run_vec(input vec_t v, input int i);
        logic [7:0] val;
        logic [7:0] prev;
        bit         ok;
        int         d0;
        if (cur[v.ch] != v.init) begin
            send_cmd(v.ch, v.init, 0);
            wait_change(v.ch, cur[v.ch][7:0], val, ok);
            check($sformatf("v%0d_jump", i), val, v.init);
            cur[v.ch] = v.init;
            cyc();
        end
        d0 = done_cnt[v.ch];
        send_cmd(v.ch, v.tgt, v.stp);
        prev = cur[v.ch][7:0];
        for (int j = 0; j < v.n; j++) begin
            wait_change(v.ch, prev, val, ok);
            if (!ok) break;
            check($sformatf("v%0d_step%0d", i, j), val, v.exp[j]);
            check($sformatf("v%0d_busy%0d", i, j), busy[v.ch], (j == v.n - 1) ? 0 : 1);
            check($sformatf("v%0d_done%0d", i, j), done[v.ch], (j == v.n - 1) ? 1 : 0);
            prev = val;
        end
        cur[v.ch] = v.tgt;
        cyc();
        check($sformatf("v%0d_done_count", i), done_cnt[v.ch] - d0, 1);
    endtask

    initial begin
        logic [7:0] val;
        bit         ok;
        int         d0;
        int         k;

        vt[0] = mk(0,   0,  10,   4, 3,   4,   8,  10,  0);
        vt[1] = mk(2, 250, 255,  20, 1, 255,   0,   0,  0);
        vt[2] = mk(2, 255,   3, 100, 3, 155,  55,   3,  0);
        vt[3] = mk(1,   0, 200,   0, 1, 200,   0,   0,  0);
        vt[4] = mk(3, 100,  90,   3, 4,  97,  94,  91, 90);
        vt[5] = mk(0,  10,   0, 255, 1,   0,   0,   0,  0);
        vt[6] = mk(1, 200, 255, 255, 1, 255,   0,   0,  0);
        vt[7] = mk(3,  90,  91, 200, 1,  91,   0,   0,  0);

        for (int c = 0; c < 4; c++) cur[c] = 0;
        tick_div       = 8'd7;
        bus.cmd_valid  = 1'b0;
        bus.cmd_ch     = 2'd0;
        bus.cmd_target = 8'd0;
        bus.cmd_step   = 8'd0;
`ifdef PWM_RAMP_IRQ_EN
        irq_clr = 1'b0;
`endif
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_duty", duty_out, 32'h0);
        check("reset_busy", busy, 4'h0);
        check("reset_done", done, 4'h0);
        check("reset_ready", bus.cmd_ready, 1);
`ifdef PWM_RAMP_IRQ_EN
        check("reset_irq", irq, 0);
`endif
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Same target as current duty on ch1: no ramp, no done
        d0 = done_cnt[1];
        send_cmd(1, cur[1], 0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("repeat_busy1", busy[1], 0);
        end
        check("repeat_done1", done_cnt[1] - d0, 0);
        check("repeat_duty1", duty_of(1), cur[1]);

        // Mid-ramp override on ch3
        send_cmd(3, 0, 0);
        wait_change(3, cur[3][7:0], val, ok);
        check("ovr_jump0", val, 0);
        cur[3] = 0;
        cyc();
`ifdef PWM_RAMP_IRQ_EN
        irq_clr = 1'b1;
        cyc();
        irq_clr = 1'b0;
        check("irq_cleared_pre", irq, 0);
`endif
        d0 = done_cnt[3];
        send_cmd(3, 100, 10);
        val = 8'd0;
        for (int j = 1; j <= 4; j++) begin
            wait_change(3, val, val, ok);
            check($sformatf("ovr_up%0d", j), val, 10 * j);
            check($sformatf("ovr_up_done%0d", j), done[3], 0);
        end
        send_cmd(3, 20, 10);
        wait_change(3, 8'd40, val, ok);
        check("ovr_down30", val, 30);
        check("ovr_down30_busy", busy[3], 1);
        wait_change(3, 8'd30, val, ok);
        check("ovr_down20", val, 20);
        check("ovr_down20_done", done[3], 1);
        check("ovr_down20_busy", busy[3], 0);
`ifdef PWM_RAMP_IRQ_EN
        check("irq_rise", irq, 1);
`endif
        cyc();
        check("ovr_done_count", done_cnt[3] - d0, 1);
`ifdef PWM_RAMP_IRQ_EN
        check("irq_sticky", irq, 1);
        irq_clr = 1'b1;
        cyc();
        irq_clr = 1'b0;
        check("irq_clr", irq, 0);
`endif
        cur[3] = 20;

        // tick_div = 0: back-to-back scans, command never accepted
        send_cmd(0, 250, 1);
        tick_div = 8'd0;
        repeat (300) cyc();
        bus.cmd_valid  = 1'b1;
        bus.cmd_ch     = 2'd1;
        bus.cmd_target = 8'd7;
        bus.cmd_step   = 8'd0;
        wait_change(0, duty_of(0), val, ok);
        if (ok) begin
            for (int i = 1; i <= 16; i++) begin
                cyc();
                check($sformatf("b2b_duty0_%0d", i), duty_of(0), int'(val) + i / 4);
                check($sformatf("b2b_ready_%0d", i), bus.cmd_ready, 0);
            end
        end
        bus.cmd_valid = 1'b0;
        tick_div      = 8'd7;
        check("b2b_busy1", busy[1], 0);
        check("b2b_duty1", duty_of(1), cur[1]);
        check("b2b_busy0", busy[0], 1);

        // Reset mid-ramp, then prescaler must restart from 0
        rst_n = 1'b0;
        #1;
        check("mid_reset_duty", duty_out, 32'h0);
        check("mid_reset_busy", busy, 4'h0);
        check("mid_reset_ready", bus.cmd_ready, 1);
        tick_div = 8'd3;
        cyc();
        cyc();
        rst_n = 1'b1;
        k = 0;
        while (bus.cmd_ready === 1'b1 && k < 20) begin
            cyc();
            k++;
        end
        if (k >= 20) timeout_fail("first_tick");
        else check("prescaler_restart_cycles", k, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
